// File: rtl/tetris_pkg.sv
// Shared board geometry, colour, state and score definitions for the tetris board blocks.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tetris_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int COLOUR_W = 6;
    localparam int ADDR_W   = 8;

    // Column index, row index, and row index with a sign bit so dst can reach -1
    localparam int COL_W   = $clog2(BOARD_W);
    localparam int ROW_W   = $clog2(BOARD_H);
    localparam int DST_W   = ROW_W + 1;
    localparam int CYC_W   = $clog2(BOARD_W + 1);
    localparam int LINES_W = $clog2(BOARD_H + 1);

    localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(BOARD_H - 1);
    localparam logic [COLOUR_W-1:0] EMPTY    = '0;

    localparam logic [15:0] SCORE_1 = 16'd40;
    localparam logic [15:0] SCORE_2 = 16'd100;
    localparam logic [15:0] SCORE_3 = 16'd300;
    localparam logic [15:0] SCORE_4 = 16'd1200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COPY_RD,
        ST_COPY_LATCH,
        ST_COPY_WR,
        ST_NEXT,
        ST_FILL,
        ST_DONE
    } lc_state_e;

    // Row-major cell address: y*BOARD_W + x
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] x,
                                                    input logic [ROW_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(BOARD_W) + ADDR_W'(x);
    endfunction

    // Points for one compaction; anything beyond four lines scores as four
    function automatic logic [15:0] score_for(input logic [LINES_W-1:0] n);
        logic [15:0] s;
        if (n == '0)                 s = 16'd0;
        else if (n == LINES_W'(1))   s = SCORE_1;
        else if (n == LINES_W'(2))   s = SCORE_2;
        else if (n == LINES_W'(3))   s = SCORE_3;
        else                         s = SCORE_4;
        return s;
    endfunction

endpackage

// File: rtl/board_addr_gen.sv
// Maps a board cell (x, y) to its RAM address.
// Latency: combinational.
// Backpressure: none.
module board_addr_gen
    import tetris_pkg::*;
(
    input  logic [COL_W-1:0]  x_i,
    input  logic [ROW_W-1:0]  y_i,
    output logic [ADDR_W-1:0] addr_o
);

    assign addr_o = cell_addr(x_i, y_i);

endmodule

// File: rtl/line_clear.sv
// Removes full board rows, shifts survivors down and zero-fills the top; optional score via LINE_CLEAR_SCORE_EN.
// Latency: per row W+2 scan cycles plus 3 per copied cell, then 1 per filled cell; complete pulses on DONE entry.
// Backpressure: none; enable low aborts to IDLE next cycle, completion waits for enable low before rearming.
module line_clear
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [COLOUR_W-1:0] ram_q,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [COLOUR_W-1:0] ram_data,
    output logic                ram_wren,
    output logic [LINES_W-1:0]  lines_cleared,
    output logic                complete
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]         score
`endif
);

    lc_state_e           state_q;
    logic [ROW_W-1:0]    src_q;
    logic [DST_W-1:0]    dst_q;     // MSB set means dst = -1
    logic [LINES_W-1:0]  cnt_q;
    logic [COL_W-1:0]    ax_q;
    logic [ROW_W-1:0]    ay_q;
    logic [CYC_W-1:0]    cyc_q;     // scan cycle; ram_q holds cell cyc_q-1
    logic                full_q;
    logic [COLOUR_W-1:0] data_q;
    logic                wren_q;
    logic                complete_q;
    logic [LINES_W-1:0]  lines_q;

    logic                row_full_d;
    logic [LINES_W-1:0]  cnt_d;
    logic [DST_W-1:0]    dst_d;
    logic                last_x;
    logic                scan_end;
    logic                src_is_dst;
    logic                finish_d;

    // Address is always the registered (ax, ay) pair, so it is glitch-free toward the RAM
    board_addr_gen u_addr (
        .x_i    (ax_q),
        .y_i    (ay_q),
        .addr_o (ram_addr)
    );

    assign ram_data      = data_q;
    assign ram_wren      = wren_q;
    assign complete      = complete_q;
    assign lines_cleared = lines_q;

    assign row_full_d = full_q & (ram_q != EMPTY);
    assign cnt_d      = (cnt_q == LINES_W'(BOARD_H)) ? cnt_q : cnt_q + 1'b1;
    assign dst_d      = dst_q - 1'b1;
    assign last_x     = (ax_q == COL_W'(BOARD_W - 1));
    assign scan_end   = (cyc_q == CYC_W'(BOARD_W));
    assign src_is_dst = ({1'b0, src_q} == dst_q);
    assign finish_d   = enable &&
                        ((state_q == ST_NEXT && src_q == '0 && dst_q[DST_W-1]) ||
                         (state_q == ST_FILL && last_x && dst_q == '0));

    // Compaction FSM: scan bottom-up, copy survivors to dst, zero-fill what is left above dst
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            cyc_q      <= '0;
            full_q     <= 1'b0;
            data_q     <= EMPTY;
            wren_q     <= 1'b0;
            complete_q <= 1'b0;
            lines_q    <= '0;
        end else if (!enable) begin
            state_q    <= ST_IDLE;
            wren_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            wren_q     <= 1'b0;
            complete_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_SCAN;
                    src_q   <= LAST_ROW;
                    dst_q   <= {1'b0, LAST_ROW};
                    cnt_q   <= '0;
                    ax_q    <= '0;
                    ay_q    <= LAST_ROW;
                    cyc_q   <= '0;
                    full_q  <= 1'b1;
                end
                ST_SCAN: begin
                    cyc_q <= cyc_q + 1'b1;
                    if (!last_x) ax_q <= ax_q + 1'b1;
                    if (cyc_q != '0) full_q <= row_full_d;
                    if (scan_end) begin
                        if (row_full_d) begin
                            cnt_q   <= cnt_d;
                            state_q <= ST_NEXT;
                        end else if (src_is_dst) begin
                            dst_q   <= dst_d;
                            state_q <= ST_NEXT;
                        end else begin
                            ax_q    <= '0;
                            ay_q    <= src_q;
                            state_q <= ST_COPY_RD;
                        end
                    end
                end
                ST_COPY_RD: begin
                    state_q <= ST_COPY_LATCH;
                end
                ST_COPY_LATCH: begin
                    data_q  <= ram_q;
                    ay_q    <= dst_q[ROW_W-1:0];
                    wren_q  <= 1'b1;
                    state_q <= ST_COPY_WR;
                end
                ST_COPY_WR: begin
                    if (last_x) begin
                        dst_q   <= dst_d;
                        state_q <= ST_NEXT;
                    end else begin
                        ax_q    <= ax_q + 1'b1;
                        ay_q    <= src_q;
                        state_q <= ST_COPY_RD;
                    end
                end
                ST_NEXT: begin
                    if (src_q == '0) begin
                        if (dst_q[DST_W-1]) begin
                            lines_q    <= cnt_q;
                            complete_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            ax_q    <= '0;
                            ay_q    <= dst_q[ROW_W-1:0];
                            data_q  <= EMPTY;
                            wren_q  <= 1'b1;
                            state_q <= ST_FILL;
                        end
                    end else begin
                        src_q   <= src_q - 1'b1;
                        ax_q    <= '0;
                        ay_q    <= src_q - 1'b1;
                        cyc_q   <= '0;
                        full_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_FILL: begin
                    if (last_x) begin
                        if (dst_q == '0) begin
                            lines_q    <= cnt_q;
                            complete_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            dst_q  <= dst_d;
                            ay_q   <= dst_d[ROW_W-1:0];
                            ax_q   <= '0;
                            wren_q <= 1'b1;
                        end
                    end else begin
                        ax_q   <= ax_q + 1'b1;
                        wren_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum_d;

    assign score_sum_d = {1'b0, score_q} + {1'b0, score_for(cnt_q)};
    assign score       = score_q;

    // Accumulate on the same edge that raises complete, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else if (finish_d) begin
            score_q <= score_sum_d[16] ? 16'hFFFF : score_sum_d[15:0];
        end
    end
`else
    logic unused_finish;
    assign unused_finish = finish_d;
`endif

endmodule

// File: tb/tb_line_clear.sv
module tb_line_clear;
    import tetris_pkg::*;

    localparam int NCELL = BOARD_W * BOARD_H;
    localparam int MEM_N = 1 << ADDR_W;

    typedef logic [NCELL*COLOUR_W-1:0] board_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [COLOUR_W-1:0] ram_q;
    logic [ADDR_W-1:0]   ram_addr;
    logic [COLOUR_W-1:0] ram_data;
    logic                ram_wren;
    logic [LINES_W-1:0]  lines_cleared;
    logic                complete;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]         score;
`endif

    // Bench-side board loading port into the RAM model
    logic                tb_we = 1'b0;
    logic                tb_clr = 1'b0;
    logic [ADDR_W-1:0]   tb_addr = '0;
    logic [COLOUR_W-1:0] tb_dat = '0;

    logic [COLOUR_W-1:0] mem [0:MEM_N-1];
    logic [COLOUR_W-1:0] exp_b [0:NCELL-1];

    int     checks = 0;
    int     fails = 0;
    int     exp_score = 0;
    int     q_lines[$];
    int     q_wr[$];
    int     q_score[$];
    board_t q_board[$];

    line_clear dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ram_q         (ram_q),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .lines_cleared (lines_cleared),
        .complete      (complete)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score         (score)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read board RAM: data for the address of cycle t appears in cycle t+1
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= EMPTY;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_dat;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int points(input int n);
        if (n == 0) return 0;
        if (n == 1) return 40;
        if (n == 2) return 100;
        if (n == 3) return 300;
        return 1200;
    endfunction

    task automatic put(input int x, input int y, input logic [COLOUR_W-1:0] v);
        tb_addr = ADDR_W'(y * BOARD_W + x);
        tb_dat  = v;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic clear_board();
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        for (int i = 0; i < NCELL; i++) exp_b[i] = EMPTY;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < BOARD_W; x++) put(x, y, COLOUR_W'(x + 1));
    endtask

    function automatic void expect_cell(input int x, input int y, input logic [COLOUR_W-1:0] v);
        exp_b[y * BOARD_W + x] = v;
    endfunction

    // Monitor: on every complete pulse pop the expected response and compare
    task automatic monitor();
        logic   en_prev = 1'b0;
        int     wr_run = 0;
        int     bad;
        board_t pk;
        forever begin
            @(negedge clk);
            if (enable && !en_prev) wr_run = 0;
            if (ram_wren) wr_run++;
            if (complete) begin
                if (q_lines.size() == 0) begin
                    chk("unexpected_complete", 1, 0);
                end else begin
                    chk("lines_cleared", int'(lines_cleared), q_lines.pop_front());
                    chk("write_count", wr_run, q_wr.pop_front());
`ifdef LINE_CLEAR_SCORE_EN
                    chk("score", int'(score), q_score.pop_front());
`else
                    void'(q_score.pop_front());
`endif
                    pk  = q_board.pop_front();
                    bad = -1;
                    for (int i = 0; i < NCELL; i++)
                        if (bad < 0 && mem[i] !== pk[i*COLOUR_W +: COLOUR_W]) bad = i;
                    checks++;
                    if (bad >= 0) begin
                        fails++;
                        $display("FAIL board cell(%0d,%0d) got=%h want=%h", bad % BOARD_W,
                                 bad / BOARD_W, mem[bad], pk[bad*COLOUR_W +: COLOUR_W]);
                    end
                end
            end
            en_prev = enable;
        end
    endtask

    task automatic run_case(input int exp_lines, input int exp_wr);
        board_t pk;
        bit     got;
        for (int i = 0; i < NCELL; i++) pk[i*COLOUR_W +: COLOUR_W] = exp_b[i];
        exp_score = exp_score + points(exp_lines);
        if (exp_score > 65535) exp_score = 65535;
        q_lines.push_back(exp_lines);
        q_wr.push_back(exp_wr);
        q_board.push_back(pk);
        q_score.push_back(exp_score);
        enable = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (complete) got = 1'b1;
        end
        chk("complete_within_bound", int'(got), 1);
        if (!got) begin
            q_lines.delete();
            q_wr.delete();
            q_board.delete();
            q_score.delete();
        end
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  got;
        fork
            monitor();
        join_none

        // Reset values
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_data", int'(ram_data), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_lines", int'(lines_cleared), 0);
        chk("rst_complete", int'(complete), 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("rst_score", int'(score), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Empty board: nothing cleared, nothing written
        clear_board();
        run_case(0, 0);

        // Row 19 full, one cell above it drops into row 19
        clear_board();
        fill_row(19);
        put(3, 18, 6'h30);
        expect_cell(3, 19, 6'h30);
        run_case(1, 200);

        // Four bottom rows full
        clear_board();
        for (int y = 16; y < 20; y++) fill_row(y);
        put(0, 15, 6'h0C);
        expect_cell(0, 19, 6'h0C);
        run_case(4, 200);

        // Rows 19 and 17 full, interleaved survivors
        clear_board();
        fill_row(19);
        fill_row(17);
        for (int x = 0; x < BOARD_W - 1; x++) put(x, 18, COLOUR_W'(x + 1));
        put(5, 16, 6'h3F);
        for (int x = 0; x < BOARD_W - 1; x++) expect_cell(x, 19, COLOUR_W'(x + 1));
        expect_cell(5, 18, 6'h3F);
        run_case(2, 200);

        // Only the top row full: no copies, one fill row
        clear_board();
        fill_row(0);
        put(2, 5, 6'h07);
        put(9, 19, 6'h15);
        expect_cell(2, 5, 6'h07);
        expect_cell(9, 19, 6'h15);
        run_case(1, 10);

        // Abort during the first scan
        clear_board();
        fill_row(19);
        put(3, 18, 6'h30);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_wren", int'(ram_wren), 0);
        chk("abort_complete", int'(complete), 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wren || complete) n++;
        end
        chk("abort_quiet", n, 0);
        chk("abort_lines_kept", int'(lines_cleared), 1);

        // Reset in the middle of a copy
        enable = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (ram_wren) got = 1'b1;
        end
        chk("midcopy_reached", int'(got), 1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("midrst_wren", int'(ram_wren), 0);
        chk("midrst_complete", int'(complete), 0);
        chk("midrst_lines", int'(lines_cleared), 0);
        chk("midrst_addr", int'(ram_addr), 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("midrst_score", int'(score), 0);
`endif
        exp_score = 0;
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wren || complete) n++;
        end
        chk("midrst_quiet", n, 0);

        // Fresh run after the aborts
        clear_board();
        fill_row(19);
        put(3, 18, 6'h30);
        expect_cell(3, 19, 6'h30);
        run_case(1, 200);

        repeat (5) @(negedge clk);
        chk("pending_expectations", q_lines.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Reader/compactor side of the board RAM. It runs after the piece writer has committed a landed tetromino.
- Scans every board row, detects full rows, shifts the surviving rows down over them, and zero-fills the freed rows at the top.
- Controller selects it with a level enable, muxes its RAM address, data and wren onto the shared ram_board port, and waits for the one-cycle complete pulse before redrawing the board from RAM.

Parameters:
- BOARD_W, 10, cells per row.
- BOARD_H, 20, rows; row 0 is the top.
- COLOUR_W, 6, cell width; value 0 means empty.
- ADDR_W, 8, RAM address width. BOARD_W*BOARD_H must be at most 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level select from the controller; high = run, low = idle/abort.
- ram_q  in  COLOUR_W  board RAM read data; valid in the cycle after its address is presented.
- ram_addr  out  ADDR_W  cell address, computed as y*BOARD_W + x.
- ram_data  out  COLOUR_W  write data.
- ram_wren  out  1  write strobe.
- lines_cleared  out  $clog2(BOARD_H+1)  number of full rows removed by the last completed run.
- complete  out  1  one-cycle pulse when the board is compacted.

Behaviour:
- Reset values: state IDLE; ram_addr 0; ram_data 0; ram_wren 0; lines_cleared 0; complete 0. Reset overrides all activity, including mid-run.
- States:
  - IDLE → SCAN when enable=1. On entry to SCAN: src=dst=BOARD_H-1, count=0.
  - SCAN reads cells (0..BOARD_W-1, src), pipelined one address per cycle. A row is full iff all BOARD_W cells are non-zero.
  - At the end of SCAN:
    - if the row is full: count++, go to NEXT;
    - else if src==dst: dst--, go to NEXT (no copy);
    - else go to COPY.
  - COPY, per cell x: COPY_RD (addr = src cell) → COPY_LATCH (capture ram_q into a data register) → COPY_WR (addr = dst cell, wren=1). Three cycles per cell. After x=BOARD_W-1: dst--, go to NEXT.
  - NEXT: if src==0, go to FILL; else src--, go to SCAN.
  - FILL writes 0 to every cell of rows dst down to 0, one cell per cycle. It is skipped when count==0, because dst is then -1.
  - After FILL, go to DONE: lines_cleared<=count and complete=1, both in the same cycle.
  - DONE holds with complete=0 until enable=0, then goes to IDLE. The block never restarts without an enable low→high cycle.
- Arithmetic: dst and src are signed, or carry one extra bit, so dst=-1 is representable. count saturates at BOARD_H.
- ram_wren is high only in COPY_WR and FILL.
- Abort: enable=0 in any state returns to IDLE next cycle with wren=0 and no complete pulse. lines_cleared keeps its previous value. Board contents after an abort mid-COPY/FILL are undefined; the controller must not abort after the first write.
- Latency: at most BOARD_H*(BOARD_W+2) + BOARD_H*BOARD_W*3 + BOARD_W*BOARD_H + 2 cycles.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined: adds output score (16 bits, reset 0). On each complete it adds 40/100/300/1200 for 1/2/3/4 lines, and 1200 for more than 4. The addition saturates at 16'hFFFF. Score is cleared only by reset.
- Undefined: no score port and no score logic.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_W, BOARD_H, COLOUR_W, ADDR_W;
  - the cell-address function y*BOARD_W+x;
  - the EMPTY colour constant (0);
  - the score table constants.
- One natural sub-module, board_addr_gen: combinational (x, y) → ram_addr, shared with draw_ram and add_to_ram.

Test Plan:
- All-zero board, enable → complete pulses once, lines_cleared=0, ram_wren never asserted.
- Row 19 full; cell (3,18)=6'h30; rest empty → lines_cleared=1, (3,19)=6'h30, rows 0–18 all zero.
- Rows 16–19 full; (0,15)=6'h0C → lines_cleared=4, (0,19)=6'h0C, every other cell zero. With LINE_CLEAR_SCORE_EN, score=1200.
- Rows 19 and 17 full; row 18 pattern A (cells 6'h01..6'h0A except x=9 empty); row 16 pattern B=(5,16)=6'h3F → row 19=A, row 18=B, rows 0–17 zero, lines_cleared=2.
- Row 0 only full → lines_cleared=1, row 0 zeroed by FILL, rows 1–19 unchanged, no COPY writes.
- enable dropped during the first SCAN, and separately reset asserted mid-COPY → IDLE next cycle, wren=0, no complete. A fresh enable after abort on the first scenario board yields lines_cleared=1.
